incubator_plant: RTL and testbench

- Behavioural thermal plant model: the sensor-producing end of the incubator control loop.
- Consumes the controller's cooler, heater and fan_rps commands and produces the signed 8-bit temperature reading the controller samples.
- Used in closed-loop benches and on FPGA demos in place of a real thermistor/ADC.
- A load handshake lets a test harness inject a temperature at any time.

---
 rtl/incubator_plant.sv | 161 ++++++++++++++++
 tb/tb_incubator_plant.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/incubator_plant.sv
// -----------------------------------------------------------------------------
// incubator_plant
// Behavioural thermal plant for the incubator control loop. Takes the
// controller's cooler/heater/fan commands and produces a signed 8-bit
// temperature reading, stepped once every TICK_DIV clocks. A valid/ready load
// port lets a harness overwrite the temperature at any time.
//
// Optional build macro: INCUBATOR_PLANT_NOISE_EN
//   Adds an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) that jitters the
//   idle drift by +/-1 on step edges. Undefined: fully deterministic.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   cooler      cooler command
//   heater      heater command
//   fan_rps     fan speed, unsigned, sets cooling rate
//   load_valid  harness requests a temperature overwrite
//   load_temp   signed temperature to load
//   load_ready  plant accepts a load this cycle
//   sensor      signed current temperature (registered)
//   tick        one-cycle pulse after each thermal step
//   mode        registered actuator mode
//
// mode  | meaning
// ------+---------------------------------------------
// IDLE  | no actuator, drift one degree toward AMBIENT
// HEAT  | heater on, +HEAT_STEP per step
// COOL  | cooler on, -max(fan_rps>>1, 1) per step
// FAULT | both actuators on, sensor frozen
// -----------------------------------------------------------------------------
module incubator_plant #(
    parameter logic signed [7:0] INIT_TEMP = 8'sd25,
    parameter logic signed [7:0] AMBIENT   = 8'sd20,
    parameter int                TICK_DIV  = 16,
    parameter int                HEAT_STEP = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cooler,
    input  logic              heater,
    input  logic [3:0]        fan_rps,
    input  logic              load_valid,
    input  logic signed [7:0] load_temp,
    output logic              load_ready,
    output logic signed [7:0] sensor,
    output logic              tick,
    output logic [1:0]        mode
);

    localparam int             PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_HEAT  = 2'b01,
        MODE_COOL  = 2'b10,
        MODE_FAULT = 2'b11
    } mode_t;

    mode_t             mode_q;
    mode_t             mode_next;
    logic [PW-1:0]     pre_q;
    logic signed [7:0] sensor_q;
    logic              tick_q;
    logic              ready_q;
    logic              load_fire;
    logic              step_edge;
    logic [3:0]        cool_mag;
    logic signed [9:0] delta;
    logic signed [9:0] sum;
    logic signed [7:0] stepped;

`ifdef INCUBATOR_PLANT_NOISE_EN
    logic [7:0] lfsr_q;
    logic       lfsr_fb;
    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
`endif

    assign load_fire  = load_valid && ready_q;
    // A load on the same edge pre-empts the step entirely.
    assign step_edge  = (pre_q == PRE_LAST) && !load_fire;
    assign load_ready = ready_q;
    assign sensor     = sensor_q;
    assign tick       = tick_q;
    assign mode       = mode_q;

    always_comb begin
        mode_next = MODE_IDLE;
        if (heater && cooler)
            mode_next = MODE_FAULT;
        else if (heater)
            mode_next = MODE_HEAT;
        else if (cooler)
            mode_next = MODE_COOL;
    end

    // Delta uses the registered mode (one-cycle-old commands) but the live
    // fan_rps at the step edge. 10-bit math leaves headroom for saturation.
    always_comb begin
        cool_mag = {1'b0, fan_rps[3:1]};
        if (cool_mag == 4'd0)
            cool_mag = 4'd1;
        delta = '0;
        case (mode_q)
            MODE_HEAT: delta = 10'(HEAT_STEP);
            MODE_COOL: delta = -$signed({6'd0, cool_mag});
            MODE_IDLE: begin
                if (sensor_q < AMBIENT)
                    delta = 10'sd1;
                else if (sensor_q > AMBIENT)
                    delta = -10'sd1;
            end
            default:   delta = '0;
        endcase
`ifdef INCUBATOR_PLANT_NOISE_EN
        if (mode_q == MODE_IDLE && lfsr_q[0])
            delta = delta + (lfsr_q[1] ? 10'sd1 : -10'sd1);
`endif
        sum = {{2{sensor_q[7]}}, sensor_q} + delta;
        if (sum > 10'sd127)
            stepped = 8'sh7F;
        else if (sum < -10'sd128)
            stepped = 8'sh80;
        else
            stepped = sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= MODE_IDLE;
            pre_q    <= '0;
            sensor_q <= INIT_TEMP;
            tick_q   <= 1'b0;
            ready_q  <= 1'b0;
`ifdef INCUBATOR_PLANT_NOISE_EN
            lfsr_q   <= 8'hA5;
`endif
        end else begin
            mode_q <= mode_next;
            tick_q <= step_edge;
            if (load_fire) begin
                sensor_q <= load_temp;
                pre_q    <= '0;
                ready_q  <= 1'b0;
            end else begin
                ready_q <= 1'b1;
                if (step_edge) begin
                    pre_q    <= '0;
                    sensor_q <= stepped;
`ifdef INCUBATOR_PLANT_NOISE_EN
                    lfsr_q   <= {lfsr_q[6:0], lfsr_fb};
`endif
                end else begin
                    pre_q <= pre_q + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_incubator_plant.sv
module tb_incubator_plant;

    logic              clk = 1'b0;
    logic              reset;
    logic              cooler;
    logic              heater;
    logic [3:0]        fan_rps;
    logic              load_valid;
    logic signed [7:0] load_temp;
    logic              load_ready;
    logic signed [7:0] sensor;
    logic              tick;
    logic [1:0]        mode;

    int errors = 0;
    int checks = 0;
    logic signed [7:0] exp_q[$];

    incubator_plant dut (
        .clk        (clk),
        .reset      (reset),
        .cooler     (cooler),
        .heater     (heater),
        .fan_rps    (fan_rps),
        .load_valid (load_valid),
        .load_temp  (load_temp),
        .load_ready (load_ready),
        .sensor     (sensor),
        .tick       (tick),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    // Waits (bounded) for the next tick, returning the negedges it took.
    task automatic wait_tick(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < 64 && !ok) begin
            @(negedge clk);
            cycles++;
            if (tick === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tick_timeout: no tick within %0d cycles, required a tick", cycles);
        end
    endtask

    // Pops n expected sensor values, one per step.
    task automatic check_steps(input string name, input int n);
        int cyc;
        bit ok;
        logic signed [7:0] exp;
        for (int i = 0; i < n; i++) begin
            wait_tick(cyc, ok);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s_sb_empty: step %0d had no expected value", name, i);
            end else begin
                exp = exp_q.pop_front();
                checks++;
                if (sensor !== exp) begin
                    errors++;
                    $display("FAIL %s_step%0d: sensor=%0d required %0d", name, i, sensor, exp);
                end
            end
        end
    endtask

    task automatic do_load(input logic signed [7:0] v);
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_pre: load_ready=%b required 1", load_ready);
        end
        load_valid = 1'b1;
        load_temp  = v;
        @(negedge clk);
        load_valid = 1'b0;
        checks++;
        if (sensor !== v) begin
            errors++;
            $display("FAIL load_value: sensor=%0d required %0d", sensor, v);
        end
    endtask

    task automatic test_reset();
        int cyc;
        bit ok;
        reset = 1'b1; cooler = 0; heater = 0; fan_rps = 0;
        load_valid = 0; load_temp = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (sensor !== 8'sd25 || mode !== 2'b00 || tick !== 1'b0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: sensor=%0d mode=%b tick=%b load_ready=%b required 25 00 0 0",
                     sensor, mode, tick, load_ready);
        end
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: load_ready=%b required 1", load_ready);
        end
        exp_q.push_back(8'sd24);
        exp_q.push_back(8'sd23);
        wait_tick(cyc, ok);
        checks++;
        if (cyc != 15) begin
            errors++;
            $display("FAIL reset_first_tick: cycles=%0d required 15", cyc);
        end
        checks++;
        if (sensor !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL reset_drift1: sensor=%0d required 24", sensor);
        end
        @(negedge clk);
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_width: tick=%b required 0", tick);
        end
        wait_tick(cyc, ok);
        checks++;
        if (cyc != 15) begin
            errors++;
            $display("FAIL reset_tick_period: cycles=%0d required 15 after width check", cyc);
        end
        checks++;
        if (sensor !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL reset_drift2: sensor=%0d required 23", sensor);
        end
    endtask

    task automatic test_heating();
        heater = 1'b1;
        do_load(8'sd25);
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(25 + 2 * i));
        check_steps("heat", 5);
        checks++;
        if (mode !== 2'b01) begin
            errors++;
            $display("FAIL heat_mode: mode=%b required 01", mode);
        end
    endtask

    task automatic test_cooling();
        heater = 1'b0; cooler = 1'b1; fan_rps = 4'd8;
        do_load(8'sd40);
        exp_q.push_back(8'sd36); exp_q.push_back(8'sd32); exp_q.push_back(8'sd28);
        check_steps("cool_fan8", 3);
        fan_rps = 4'd1;
        exp_q.push_back(8'sd27);
        check_steps("cool_fan1", 1);
        fan_rps = 4'd0;
        exp_q.push_back(8'sd26);
        check_steps("cool_fan0", 1);
        checks++;
        if (mode !== 2'b10) begin
            errors++;
            $display("FAIL cool_mode: mode=%b required 10", mode);
        end
    endtask

    task automatic test_drift_fault();
        heater = 0; cooler = 0; fan_rps = 0;
        do_load(8'sd23);
        exp_q.push_back(8'sd22); exp_q.push_back(8'sd21);
        exp_q.push_back(8'sd20); exp_q.push_back(8'sd20);
        check_steps("drift", 4);
        heater = 1; cooler = 1;
        @(negedge clk);
        checks++;
        if (mode !== 2'b11) begin
            errors++;
            $display("FAIL fault_mode: mode=%b required 11", mode);
        end
        repeat (3) exp_q.push_back(8'sd20);
        check_steps("fault", 3);
    endtask

    task automatic test_saturation();
        heater = 1; cooler = 0; fan_rps = 0;
        do_load(8'sd126);
        exp_q.push_back(8'sd127); exp_q.push_back(8'sd127);
        check_steps("sat_hi", 2);
        heater = 0; cooler = 1; fan_rps = 4'd15;
        do_load(-8'sd127);
        exp_q.push_back(-8'sd128); exp_q.push_back(-8'sd128);
        check_steps("sat_lo", 2);
    endtask

    task automatic test_load_on_step();
        int cyc;
        bit ok;
        heater = 0; cooler = 0; fan_rps = 0;
        do_load(8'sd0);
        exp_q.push_back(8'sd1);
        check_steps("pre_step", 1);
        // Now just after step edge S; the posedge following 15 more negedges is S+16.
        repeat (15) @(negedge clk);
        load_valid = 1'b1;
        load_temp  = -8'sd5;
        @(negedge clk);
        load_valid = 1'b0;
        checks++;
        if (sensor !== -8'sd5 || tick !== 1'b0) begin
            errors++;
            $display("FAIL load_on_step: sensor=%0d tick=%b required -5 0", sensor, tick);
        end
        exp_q.push_back(-8'sd4);
        wait_tick(cyc, ok);
        checks++;
        if (cyc != 16) begin
            errors++;
            $display("FAIL load_on_step_period: cycles=%0d required 16", cyc);
        end
        checks++;
        if (sensor !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL load_on_step_next: sensor=%0d required -4", sensor);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        load_valid = 1'b1;
        load_temp  = 8'sd10;
        @(negedge clk);
        load_temp  = 8'sd50;
        checks++;
        if (sensor !== 8'sd10 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: sensor=%0d load_ready=%b required 10 0", sensor, load_ready);
        end
        @(negedge clk);
        load_valid = 1'b0;
        checks++;
        if (sensor !== 8'sd10 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ignored: sensor=%0d load_ready=%b required 10 1", sensor, load_ready);
        end
        @(negedge clk);
        checks++;
        if (sensor !== 8'sd10) begin
            errors++;
            $display("FAIL b2b_not_queued: sensor=%0d required 10", sensor);
        end
    endtask

    task automatic test_reset_mid();
        cooler = 1; fan_rps = 4'd8;
        do_load(8'sd40);
        exp_q.push_back(8'sd36);
        check_steps("pre_reset", 1);
        repeat (5) @(negedge clk);
        load_valid = 1'b1;
        load_temp  = 8'sd77;
        reset      = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        load_valid = 1'b0;
        checks++;
        if (sensor !== 8'sd25 || mode !== 2'b00 || tick !== 1'b0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: sensor=%0d mode=%b tick=%b load_ready=%b required 25 00 0 0",
                     sensor, mode, tick, load_ready);
        end
        @(negedge clk);
        checks++;
        if (sensor !== 8'sd25 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_after: sensor=%0d load_ready=%b required 25 1", sensor, load_ready);
        end
        cooler = 0; fan_rps = 0;
    endtask

    initial begin
        test_reset();
        test_heating();
        test_cooling();
        test_drift_fault();
        test_saturation();
        test_load_on_step();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
